// File: rtl/div_radix2_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The requester holds start until it sees done; results are held until the next done.
interface div_radix2_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic             signed_div;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, flush, signed_div, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, flush, signed_div, dividend, divisor,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// MSB first, with sign correction applied on the final step.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    div_radix2_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ZERO, CALC, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] work_quot;
    logic [WIDTH-1:0] divisor_mag;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_quot;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;
    logic             last_step;

    // Magnitudes wrap naturally: |most-negative| keeps its bit pattern as an unsigned value.
    always_comb begin
        dividend_abs = bus.dividend;
        divisor_abs  = bus.divisor;
        if (bus.signed_div && bus.dividend[WIDTH-1]) dividend_abs = -bus.dividend;
        if (bus.signed_div && bus.divisor[WIDTH-1])  divisor_abs  = -bus.divisor;

        shifted   = {part_rem, work_quot[WIDTH-1]};
        trial     = shifted - {1'b0, divisor_mag};
        next_rem  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        next_quot = {work_quot[WIDTH-2:0], ~trial[WIDTH]};

        quot_final = neg_q ? -next_quot : next_quot;
        rem_final  = neg_r ? -next_rem  : next_rem;
        last_step  = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            part_rem      <= '0;
            work_quot     <= '0;
            divisor_mag   <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
        end else begin
            bus.done <= 1'b0;
            if (bus.flush) begin
                state    <= IDLE;
                count    <= '0;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            neg_q       <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                            neg_r       <= bus.signed_div & bus.dividend[WIDTH-1];
                            divisor_mag <= divisor_abs;
                            part_rem    <= '0;
                            count       <= '0;
                            bus.busy    <= 1'b1;
                            // The zero path keeps the raw dividend, it becomes the remainder as-is.
                            if (bus.divisor == '0) begin
                                work_quot <= bus.dividend;
                                state     <= ZERO;
                            end else begin
                                work_quot <= dividend_abs;
                                state     <= CALC;
                            end
                        end
                    end
                    ZERO: begin
                        bus.quotient  <= '1;
                        bus.remainder <= work_quot;
                        bus.done      <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= DONE;
                    end
                    CALC: begin
                        part_rem  <= next_rem;
                        work_quot <= next_quot;
                        count     <= count + CW'(1);
                        if (last_step) begin
                            bus.quotient  <= quot_final;
                            bus.remainder <= rem_final;
                            bus.done      <= 1'b1;
                            bus.busy      <= 1'b0;
                            state         <= DONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
